// File: rtl/digit_split_pkg.sv
// digit_split_pkg
// Shared types and helpers for the sequential binary-to-BCD splitter.
//   state_t     : converter FSM states (IDLE / CONV / DONE)
//   BLANK_DIGIT : code driven on a blanked leading-zero digit
//   cnt_width() : width of a counter that must hold 0..n-1 (never below 1)
package digit_split_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] BLANK_DIGIT = 4'hF;

   // $clog2(1) is 0, which would give a zero-width counter.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bcd_add3_row.sv
// bcd_add3_row
// One row of the shift-add-3 converter: every digit >= 5 gets +3 so that
// the following left shift carries correctly into the next decade.
//   din   : ND packed BCD digits, digit 0 in the LSBs
//   dout  : digits after the conditional +3
//   carry : MSB of the top digit after +3, i.e. the bit the next shift drops
module bcd_add3_row #(
   parameter int ND = 2
) (
   input  logic [ND*4-1:0] din,
   output logic [ND*4-1:0] dout,
   output logic            carry
);

   always_comb begin
      dout = '0;
      for (int d = 0; d < ND; d++) begin
         if (din[d*4 +: 4] >= 4'd5) dout[d*4 +: 4] = din[d*4 +: 4] + 4'd3;
         else                       dout[d*4 +: 4] = din[d*4 +: 4];
      end
   end

   assign carry = dout[ND*4-1];

endmodule

// File: rtl/digit_split_seq.sv
// digit_split_seq
// Multi-channel sequential binary-to-BCD splitter, one input bit per clock.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : conversion request, honoured only while idle
//   data_in    : CH channels of W bits, channel c = data_in[c*W +: W]
//   busy       : high from the accepting edge until done is raised
//   done       : one-cycle pulse, bcd_out/ovf refreshed on the same edge
//   bcd_out    : channel c digit d (d=0 units) = bcd_out[(c*ND+d)*4 +: 4]
//   ovf        : bit c set when channel c value >= 10^ND
// Handshake: start is a level sampled on each edge while idle; there is no
// queuing, so a request raised while busy is dropped and must be re-issued.
module digit_split_seq
   import digit_split_pkg::*;
#(
   parameter int CH  = 2,
   parameter int W   = 8,
   parameter int ND  = 2,
   parameter int LZB = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [CH*W-1:0]    data_in,
   output logic               busy,
   output logic               done,
   output logic [CH*ND*4-1:0] bcd_out,
   output logic [CH-1:0]      ovf
);

   localparam int CW = cnt_width(W);
   localparam int HW = cnt_width(CH);
   localparam int IW = cnt_width(CH*W);
   localparam int BW = ND*4;

   state_t             state, state_nxt;
   logic [CH*W-1:0]    data_lat;
   logic [CW-1:0]      cnt;
   logic [HW-1:0]      ch;
   logic [BW-1:0]      scr;
   logic               sticky;
   logic [CH*BW-1:0]   stg_bcd;
   logic [CH-1:0]      stg_ovf;
   logic [BW-1:0]      a3;
   logic               a3_c;
   logic [BW-1:0]      shifted;
   logic [IW-1:0]      bit_idx;
   logic               last_bit;
   logic               last_ch;
   logic [CH*BW-1:0]   shown;

   // The latched word is read in place, MSB first, instead of being copied
   // into a per-channel shift register.
   assign bit_idx  = IW'(ch) * IW'(W) + IW'(cnt);
   assign last_bit = (cnt == '0);
   assign last_ch  = (ch == HW'(CH-1));
   assign busy     = (state != IDLE);

   bcd_add3_row #(.ND(ND)) u_add3 (
      .din   (scr),
      .dout  (a3),
      .carry (a3_c)
   );

   assign shifted = {a3[BW-2:0], data_lat[bit_idx]};

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CONV;
         CONV:    if (last_bit && last_ch) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Leading-zero blanking. An overflowed channel is shown unblanked so the
   // wrapped value is not mistaken for a small in-range one.
   always_comb begin
      logic lead;
      lead  = 1'b0;
      shown = stg_bcd;
      if (LZB != 0) begin
         for (int c = 0; c < CH; c++) begin
            lead = !stg_ovf[c];
            for (int d = ND-1; d >= 1; d--) begin
               if (lead && (stg_bcd[(c*ND+d)*4 +: 4] == 4'd0))
                  shown[(c*ND+d)*4 +: 4] = BLANK_DIGIT;
               else
                  lead = 1'b0;
            end
         end
      end
   end

   // Datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_lat <= '0;
         cnt      <= '0;
         ch       <= '0;
         scr      <= '0;
         sticky   <= 1'b0;
         stg_bcd  <= '0;
         stg_ovf  <= '0;
         bcd_out  <= '0;
         ovf      <= '0;
         done     <= 1'b0;
      end else begin
         done <= (state == DONE);
         case (state)
            IDLE: begin
               if (start) begin
                  data_lat <= data_in;
                  ch       <= '0;
                  cnt      <= CW'(W-1);
                  scr      <= '0;
                  sticky   <= 1'b0;
               end
            end
            CONV: begin
               scr    <= shifted;
               sticky <= sticky | a3_c;
               cnt    <= cnt - 1'b1;
               if (last_bit) begin
                  stg_bcd[ch*BW +: BW] <= shifted;
                  stg_ovf[ch]          <= sticky | a3_c;
                  if (!last_ch) begin
                     ch     <= ch + 1'b1;
                     cnt    <= CW'(W-1);
                     scr    <= '0;
                     sticky <= 1'b0;
                  end
               end
            end
            DONE: begin
               bcd_out <= shown;
               ovf     <= stg_ovf;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_digit_split_seq.sv
// tb_digit_split_seq
// Directed bench for digit_split_seq: default build (CH=2, W=8, ND=2),
// a blanking build (CH=1, W=10, ND=3, LZB=1) and a wide build
// (CH=1, W=16, ND=5). Expected digits are written out by hand.
module tb_digit_split_seq;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // default instance
   logic        start_a;
   logic [15:0] data_a;
   logic        busy_a, done_a;
   logic [15:0] bcd_a;
   logic [1:0]  ovf_a;

   // blanking instance
   logic        start_b;
   logic [9:0]  data_b;
   logic        busy_b, done_b;
   logic [11:0] bcd_b;
   logic [0:0]  ovf_b;

   // wide instance
   logic        start_c;
   logic [15:0] data_c;
   logic        busy_c, done_c;
   logic [19:0] bcd_c;
   logic [0:0]  ovf_c;

   int n_tests = 0;
   int n_fail  = 0;

   digit_split_seq u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .data_in(data_a),
      .busy(busy_a), .done(done_a), .bcd_out(bcd_a), .ovf(ovf_a)
   );

   digit_split_seq #(.CH(1), .W(10), .ND(3), .LZB(1)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .data_in(data_b),
      .busy(busy_b), .done(done_b), .bcd_out(bcd_b), .ovf(ovf_b)
   );

   digit_split_seq #(.CH(1), .W(16), .ND(5), .LZB(0)) u_dut_c (
      .clk(clk), .rst_n(rst_n), .start(start_c), .data_in(data_c),
      .busy(busy_c), .done(done_c), .bcd_out(bcd_c), .ovf(ovf_c)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One conversion on the default instance; data_in is scrambled after
   // acceptance to show it has no effect.
   task automatic conv_a(input string tag, input logic [7:0] v1, input logic [7:0] v0,
                         input logic [15:0] exp_bcd, input logic [1:0] exp_ovf);
      int lat;
      bit seen;
      data_a  = {v1, v0};
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      data_a  = ~data_a;
      check({tag, " busy"}, busy_a, 1);
      lat = 0; seen = 0;
      while (!seen && lat < 100) begin
         @(posedge clk); #1;
         lat++;
         if (done_a) seen = 1;
      end
      check({tag, " latency"}, lat, 17);
      check({tag, " bcd"}, bcd_a, exp_bcd);
      check({tag, " ovf"}, ovf_a, exp_ovf);
      check({tag, " busy_off"}, busy_a, 0);
      @(posedge clk); #1;
      check({tag, " done_pulse"}, done_a, 0);
      check({tag, " bcd_hold"}, bcd_a, exp_bcd);
   endtask

   task automatic conv_b(input string tag, input logic [9:0] v,
                         input logic [11:0] exp_bcd, input logic exp_ovf);
      int lat;
      bit seen;
      data_b  = v;
      start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      check({tag, " busy"}, busy_b, 1);
      lat = 0; seen = 0;
      while (!seen && lat < 100) begin
         @(posedge clk); #1;
         lat++;
         if (done_b) seen = 1;
      end
      check({tag, " latency"}, lat, 11);
      check({tag, " bcd"}, bcd_b, exp_bcd);
      check({tag, " ovf"}, ovf_b, exp_ovf);
      @(posedge clk); #1;
   endtask

   task automatic conv_c(input string tag, input logic [15:0] v,
                         input logic [19:0] exp_bcd, input logic exp_ovf);
      int lat;
      bit seen;
      data_c  = v;
      start_c = 1'b1;
      @(posedge clk); #1;
      start_c = 1'b0;
      check({tag, " busy"}, busy_c, 1);
      lat = 0; seen = 0;
      while (!seen && lat < 100) begin
         @(posedge clk); #1;
         lat++;
         if (done_c) seen = 1;
      end
      check({tag, " latency"}, lat, 17);
      check({tag, " bcd"}, bcd_c, exp_bcd);
      check({tag, " ovf"}, ovf_c, exp_ovf);
      @(posedge clk); #1;
   endtask

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int first_n;
      rst_n   = 1'b0;
      start_a = 1'b0; data_a = '0;
      start_b = 1'b0; data_b = '0;
      start_c = 1'b0; data_c = '0;
      repeat (3) @(posedge clk);
      #1;

      // reset state
      check("rst bcd", bcd_a, 16'h0000);
      check("rst ovf", ovf_a, 2'b00);
      check("rst busy", busy_a, 0);
      check("rst done", done_a, 0);
      check("rst bcd_b", bcd_b, 12'h000);
      check("rst busy_b", busy_b, 0);
      check("rst bcd_c", bcd_c, 20'h00000);
      check("rst busy_c", busy_c, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // main function and boundaries
      conv_a("basic", 8'd27, 8'd45, 16'h2745, 2'b00);
      conv_a("max_in_range", 8'd0, 8'd99, 16'h0099, 2'b00);
      conv_a("overflow", 8'd100, 8'd255, 16'h0055, 2'b11);

      // start held high: a new conversion every 18 cycles
      data_a  = {8'd63, 8'd8};
      start_a = 1'b1;
      cnt = 0;
      for (int n = 1; n <= 72; n++) begin
         @(posedge clk); #1;
         if (done_a) begin
            cnt++;
            check("held done_pos", n, 18*cnt);
         end
      end
      start_a = 1'b0;
      check("held done_count", cnt, 4);
      check("held bcd", bcd_a, 16'h6308);
      repeat (2) @(posedge clk); #1;

      // start pulses during CONV and DONE are dropped
      data_a  = {8'd50, 8'd7};
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      cnt = 0; first_n = 0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (done_a) begin
            cnt++;
            if (first_n == 0) first_n = n;
         end
         start_a = (n == 5 || n == 16);
      end
      start_a = 1'b0;
      check("ignored done_count", cnt, 1);
      check("ignored done_pos", first_n, 17);
      check("ignored bcd", bcd_a, 16'h5007);

      // reset in the middle of a conversion
      data_a  = {8'd88, 8'd11};
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      repeat (9) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("abort bcd", bcd_a, 16'h0000);
      check("abort ovf", ovf_a, 2'b00);
      check("abort busy", busy_a, 0);
      check("abort done", done_a, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      cnt = 0;
      for (int n = 1; n <= 25; n++) begin
         @(posedge clk); #1;
         if (done_a) cnt++;
      end
      check("abort no_done", cnt, 0);
      check("abort bcd_hold", bcd_a, 16'h0000);
      conv_a("fresh", 8'd12, 8'd34, 16'h1234, 2'b00);

      // leading-zero blanking
      conv_b("lzb_7", 10'd7, 12'hFF7, 1'b0);
      conv_b("lzb_40", 10'd40, 12'hF40, 1'b0);
      conv_b("lzb_0", 10'd0, 12'hFF0, 1'b0);
      conv_b("lzb_1000", 10'd1000, 12'h000, 1'b1);
      conv_b("lzb_999", 10'd999, 12'h999, 1'b0);

      // wide single channel
      conv_c("wide_65535", 16'd65535, 20'h65535, 1'b0);
      conv_c("wide_1024", 16'd1024, 20'h01024, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
